hack_cpu: RTL and testbench



---
 rtl/hack_cpu_if.sv | 21 ++
 rtl/hack_cpu.sv | 90 +++++++++
 tb/tb_hack_cpu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hack_cpu_if.sv
// Hack CPU bus: ROM fetch, data-memory read/write and the ready stall input.
// master = CPU side, slave = memory/ROM side.
interface hack_cpu_if;
  logic        ready;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  modport master (
    input  ready, instruction, inM,
    output outM, writeM, addressM, pc
  );

  modport slave (
    output ready, instruction, inM,
    input  outM, writeM, addressM, pc
  );
endinterface

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU: A/D/PC registers around the Hack ALU, one instruction per edge.
// Outputs are combinational from state and inputs; ready=0 freezes all state and masks writeM.
module hack_cpu (
  input  logic       clock,
  input  logic       reset,
  hack_cpu_if.master bus
);

  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;

  logic [15:0] ins;
  logic        is_c;
  logic        a_bit, zx, nx, zy, ny, f, no;
  logic        d1, d2, d3, j1, j2, j3;

  assign ins   = bus.instruction;
  assign is_c  = ins[15];
  assign a_bit = ins[12];
  assign zx    = ins[11];
  assign nx    = ins[10];
  assign zy    = ins[9];
  assign ny    = ins[8];
  assign f     = ins[7];
  assign no    = ins[6];
  assign d1    = ins[5];
  assign d2    = ins[4];
  assign d3    = ins[3];
  assign j1    = ins[2];
  assign j2    = ins[1];
  assign j3    = ins[0];

  logic unused_ins;
  assign unused_ins = ^ins[14:13];

  // Hack ALU: x = D, y = A or M selected by the a bit
  logic [15:0] alu_x, alu_y, x1, y1, alu_f, alu_out;
  logic        zr, ng;

  assign alu_x = d_q;
  assign alu_y = a_bit ? bus.inM : a_q;

  always_comb begin
    x1 = zx ? 16'h0000 : alu_x;
    x1 = nx ? ~x1 : x1;
    y1 = zy ? 16'h0000 : alu_y;
    y1 = ny ? ~y1 : y1;
    alu_f   = f ? (x1 + y1) : (x1 & y1);
    alu_out = no ? ~alu_f : alu_f;
  end

  assign zr = (alu_out == 16'h0000);
  assign ng = alu_out[15];

  logic jump;
  assign jump = is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr));

  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q + 15'd1;
    if (!is_c) begin
      a_d = ins;
    end else begin
      if (d1) a_d = alu_out;
      if (d2) d_d = alu_out;
    end
    // Jump target is the A value before this instruction's own A update
    if (jump) pc_d = a_q[14:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 15'h0000;
    end else if (bus.ready) begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign bus.outM     = alu_out;
  assign bus.writeM   = bus.ready & ~reset & is_c & d3;
  assign bus.addressM = a_q[14:0];
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu: reset, load/copy, memory operand, jumps, stall, PC wrap.
module tb_hack_cpu;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  hack_cpu_if bus ();

  hack_cpu u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs and let the combinational outputs settle (mid-cycle)
  task automatic drive(input logic [15:0] ins, input logic [15:0] m, input logic rdy);
    bus.instruction = ins;
    bus.inM         = m;
    bus.ready       = rdy;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [15:0] ins, input logic [15:0] m, input logic rdy);
    drive(ins, m, rdy);
    edge_step();
  endtask

  // outM with comp=D and no dest/jump exposes D without changing state
  task automatic check_d(input string tag, input logic [15:0] exp);
    drive(16'hE300, 16'h0000, 1'b0);
    check(tag, bus.outM, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(16'hE308, 16'h1111, 1'b1);
    repeat (3) edge_step();
    check("rst_pc", {1'b0, bus.pc}, 16'h0000);
    check("rst_addr", {1'b0, bus.addressM}, 16'h0000);
    check("rst_writeM", {15'h0, bus.writeM}, 16'h0000);
    check_d("rst_D", 16'h0000);

    reset = 1'b0;
    #1;
    // Load and copy
    step(16'h0005, 16'h0000, 1'b1);
    check("ld_A", {1'b0, bus.addressM}, 16'h0005);
    check("ld_pc", {1'b0, bus.pc}, 16'h0001);
    step(16'hEC10, 16'h0000, 1'b1);
    check_d("cp_D", 16'h0005);
    check("cp_pc", {1'b0, bus.pc}, 16'h0002);
    drive(16'hE308, 16'h0000, 1'b1);
    check("mw_writeM", {15'h0, bus.writeM}, 16'h0001);
    check("mw_addr", {1'b0, bus.addressM}, 16'h0005);
    check("mw_outM", bus.outM, 16'h0005);
    edge_step();
    check("mw_pc", {1'b0, bus.pc}, 16'h0003);

    // Memory operand D=M+1
    step(16'h0007, 16'h0000, 1'b1);
    drive(16'hFDD0, 16'h0009, 1'b1);
    check("mo_writeM", {15'h0, bus.writeM}, 16'h0000);
    check("mo_outM", bus.outM, 16'h000A);
    edge_step();
    check_d("mo_D", 16'h000A);
    check("mo_pc", {1'b0, bus.pc}, 16'h0005);

    // Jumps: D=3, A=0x10, D;JGT taken
    step(16'h0003, 16'h0000, 1'b1);
    step(16'hEC10, 16'h0000, 1'b1);
    step(16'h0010, 16'h0000, 1'b1);
    check("pre_jgt_pc", {1'b0, bus.pc}, 16'h0008);
    step(16'hE301, 16'h0000, 1'b1);
    check("jgt_pos_pc", {1'b0, bus.pc}, 16'h0010);
    step(16'hEA90, 16'h0000, 1'b1);
    step(16'hE301, 16'h0000, 1'b1);
    check("jgt_zero_pc", {1'b0, bus.pc}, 16'h0012);
    step(16'hEE90, 16'h0000, 1'b1);
    check_d("neg_D", 16'hFFFF);
    step(16'hE301, 16'h0000, 1'b1);
    check("jgt_neg_pc", {1'b0, bus.pc}, 16'h0014);
    step(16'hE304, 16'h0000, 1'b1);
    check("jlt_neg_pc", {1'b0, bus.pc}, 16'h0010);
    step(16'h0020, 16'h0000, 1'b1);
    step(16'hEA87, 16'h0000, 1'b1);
    check("jmp_pc", {1'b0, bus.pc}, 16'h0020);
    // A=1;JMP jumps to the old A
    step(16'hEFE7, 16'h0000, 1'b1);
    check("jmp_oldA_pc", {1'b0, bus.pc}, 16'h0020);
    check("jmp_newA", {1'b0, bus.addressM}, 16'h0001);

    // Stall during M=D
    for (int i = 0; i < 3; i++) begin
      drive(16'hE308, 16'h0000, 1'b0);
      check("stall_writeM", {15'h0, bus.writeM}, 16'h0000);
      edge_step();
      check("stall_pc", {1'b0, bus.pc}, 16'h0020);
      check("stall_addr", {1'b0, bus.addressM}, 16'h0001);
    end
    check_d("stall_D", 16'hFFFF);
    drive(16'hE308, 16'h0000, 1'b1);
    check("unstall_writeM", {15'h0, bus.writeM}, 16'h0001);
    check("unstall_outM", bus.outM, 16'hFFFF);
    edge_step();
    check("unstall_pc", {1'b0, bus.pc}, 16'h0021);
    drive(16'hE300, 16'h0000, 1'b1);
    check("post_writeM", {15'h0, bus.writeM}, 16'h0000);

    // PC wrap
    step(16'h7FFF, 16'h0000, 1'b1);
    step(16'hEA87, 16'h0000, 1'b1);
    check("wrap_jmp_pc", {1'b0, bus.pc}, 16'h7FFF);
    step(16'hE300, 16'h0000, 1'b1);
    check("wrap_pc", {1'b0, bus.pc}, 16'h0000);

    // Asynchronous reset between edges
    step(16'h1234, 16'h0000, 1'b1);
    check("pre_arst_addr", {1'b0, bus.addressM}, 16'h1234);
    check("pre_arst_pc", {1'b0, bus.pc}, 16'h0001);
    reset = 1'b1;
    #1;
    check("arst_pc", {1'b0, bus.pc}, 16'h0000);
    check("arst_addr", {1'b0, bus.addressM}, 16'h0000);
    check_d("arst_D", 16'h0000);
    reset = 1'b0;
    #1;
    step(16'h0042, 16'h0000, 1'b1);
    check("post_arst_pc", {1'b0, bus.pc}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
